// File: rtl/sram_pkg.sv
// Types and elaboration helpers shared by the async-SRAM controller files.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RECOVER
    } state_t;

    localparam int WAIT_CYC_MAX = 15;
    localparam int CNT_W        = 4;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/sram_dq_buf.sv
// Tri-state buffer that keeps the SRAM data inout out of the controller logic.
module sram_dq_buf #(
    parameter int DATA_W = 16
) (
    input  logic              i_drive_en,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    inout  wire  [DATA_W-1:0] io_dq
);

    assign io_dq   = i_drive_en ? i_wdata : {DATA_W{1'bz}};
    assign o_rdata = io_dq;

endmodule

// File: rtl/sram_ctrl.sv
// Single-port async-SRAM controller: valid/ready requests, byte masking,
// configurable access wait cycles, registered strobes and data-bus ownership.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 1,
    localparam int BE_W    = be_width(DATA_W)
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic [BE_W-1:0]   SRAM_BE_N
);

    if (WAIT_CYC < 0 || WAIT_CYC > WAIT_CYC_MAX || (DATA_W % 8) != 0) begin : g_bad_param
        $error("sram_ctrl: WAIT_CYC must be 0..15 and DATA_W a multiple of 8");
    end

    state_t             r_state,    w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
    logic               r_we,       w_we_nxt;
    logic [BE_W-1:0]    r_be,       w_be_nxt;
    logic [ADDR_W-1:0]  r_addr,     w_addr_nxt;
    logic [DATA_W-1:0]  r_wdata,    w_wdata_nxt;
    logic               r_drive_en, w_drive_en_nxt;
    logic               r_ce_n,     w_ce_n_nxt;
    logic               r_oe_n,     w_oe_n_nxt;
    logic               r_we_n,     w_we_n_nxt;
    logic [BE_W-1:0]    r_be_n,     w_be_n_nxt;
    logic               r_rd_valid, w_rd_valid_nxt;
    logic [DATA_W-1:0]  r_rd_data,  w_rd_data_nxt;
    logic [DATA_W-1:0]  w_dq_in;
    logic [DATA_W-1:0]  w_be_mask;

    sram_dq_buf #(.DATA_W(DATA_W)) u_dq_buf (
        .i_drive_en (r_drive_en),
        .i_wdata    (r_wdata),
        .o_rdata    (w_dq_in),
        .io_dq      (SRAM_DQ)
    );

    always_comb begin
        w_be_mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            w_be_mask[i*8 +: 8] = {8{r_be[i]}};
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_we_nxt       = r_we;
        w_be_nxt       = r_be;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_drive_en_nxt = r_drive_en;
        w_ce_n_nxt     = r_ce_n;
        w_oe_n_nxt     = r_oe_n;
        w_we_n_nxt     = r_we_n;
        w_be_n_nxt     = r_be_n;
        w_rd_valid_nxt = 1'b0;
        w_rd_data_nxt  = r_rd_data;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_nxt    = ACCESS;
                    w_cnt_nxt      = CNT_W'(WAIT_CYC);
                    w_we_nxt       = req_we;
                    w_be_nxt       = req_be;
                    w_addr_nxt     = req_addr;
                    w_wdata_nxt    = req_wdata;
                    w_ce_n_nxt     = 1'b0;
                    w_be_n_nxt     = ~req_be;
                    w_we_n_nxt     = ~req_we;
                    w_oe_n_nxt     = req_we;
                    w_drive_en_nxt = req_we;
                end
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RECOVER;
                    w_ce_n_nxt  = 1'b1;
                    w_oe_n_nxt  = 1'b1;
                    w_we_n_nxt  = 1'b1;
                    w_be_n_nxt  = '1;
                    if (!r_we) begin
                        w_rd_valid_nxt = 1'b1;
                        w_rd_data_nxt  = w_dq_in & w_be_mask;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RECOVER: begin
                // Write data was held through this cycle; release only on return to IDLE.
                w_state_nxt    = IDLE;
                w_drive_en_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_drive_en <= 1'b0;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_be_n     <= '1;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_we       <= w_we_nxt;
            r_be       <= w_be_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_drive_en <= w_drive_en_nxt;
            r_ce_n     <= w_ce_n_nxt;
            r_oe_n     <= w_oe_n_nxt;
            r_we_n     <= w_we_n_nxt;
            r_be_n     <= w_be_n_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_rd_data  <= w_rd_data_nxt;
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign SRAM_ADDR = r_addr;
    assign SRAM_CE_N = r_ce_n;
    assign SRAM_OE_N = r_oe_n;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_BE_N = r_be_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: three instances (WAIT_CYC = 1, 0, 3), each
// attached to a behavioural async SRAM with a 10 ns read access time.
`timescale 1ns/1ps
module tb_sram_ctrl;

    localparam int NI = 3;

    function automatic int wc_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NI-1:0]  req_valid;
    logic [NI-1:0]  req_ready;
    logic           req_we;
    logic [17:0]    req_addr;
    logic [15:0]    req_wdata;
    logic [1:0]     req_be;
    logic [NI-1:0]  rd_valid;
    logic [15:0]    rd_data   [NI];
    logic [17:0]    sram_addr [NI];
    logic [NI-1:0]  ce_n, oe_n, we_n;
    logic [1:0]     be_n      [NI];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        wire  [15:0] dq;
        wire         rd_en;
        logic [15:0] mem [64];
        int          viol = 0;

        sram_ctrl #(.ADDR_W(18), .DATA_W(16), .WAIT_CYC(wc_of(g))) u_dut (
            .CLOCK_50  (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .req_be    (req_be),
            .rd_valid  (rd_valid[g]),
            .rd_data   (rd_data[g]),
            .SRAM_ADDR (sram_addr[g]),
            .SRAM_DQ   (dq),
            .SRAM_CE_N (ce_n[g]),
            .SRAM_OE_N (oe_n[g]),
            .SRAM_WE_N (we_n[g]),
            .SRAM_BE_N (be_n[g])
        );

        assign #10 rd_en = !ce_n[g] && !oe_n[g] && we_n[g];
        assign dq = rd_en ? mem[sram_addr[g][5:0]] : 16'hzzzz;

        always @(ce_n[g] or we_n[g] or be_n[g] or sram_addr[g] or dq) begin
            if (!ce_n[g] && !we_n[g]) begin
                if (!be_n[g][0]) mem[sram_addr[g][5:0]][7:0]  = dq[7:0];
                if (!be_n[g][1]) mem[sram_addr[g][5:0]][15:8] = dq[15:8];
            end
        end

        always @(negedge clk) if (!oe_n[g] && u_dut.r_drive_en) viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int k);
        int n = 0;
        @(negedge clk);
        while (req_ready[k] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("ready_timeout", 32'(req_ready[k]), 1);
    endtask

    // Returns 1 ns after the accept edge.
    task automatic send(input int k, input logic we, input logic [17:0] a,
                        input logic [15:0] d, input logic [1:0] be);
        req_we       = we;
        req_addr     = a;
        req_wdata    = d;
        req_be       = be;
        req_valid[k] = 1'b1;
        wait_ready(k);
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
    endtask

    task automatic write_op(input int k, input logic [17:0] a, input logic [15:0] d,
                            input logic [1:0] be);
        send(k, 1'b1, a, d, be);
        wait_ready(k);
    endtask

    task automatic run_read(input int k, input logic [17:0] a, input logic [1:0] be,
                            input logic [15:0] exp);
        int n      = wc_of(k) + 1;
        int lat    = 0;
        int pulses = 0;
        logic [15:0] data = '0;
        send(k, 1'b0, a, 16'h0, be);
        for (int c = 1; c <= n + 2; c++) begin
            @(negedge clk);
            if (rd_valid[k] === 1'b1) begin
                pulses++;
                lat  = c;
                data = rd_data[k];
            end
            check("rd_oe_n", 32'(oe_n[k]), (c <= n) ? 0 : 1);
        end
        check("rd_latency", lat, n + 1);
        check("rd_pulses", pulses, 1);
        check("rd_data", 32'(data), 32'(exp));
        check("rd_ready_again", 32'(req_ready[k]), 1);
        check("rd_data_hold", 32'(rd_data[k]), 32'(exp));
    endtask

    task automatic back_to_back(input int k, input int base);
        int acc [4];
        req_we = 1'b1;
        req_be = 2'b11;
        for (int i = 0; i < 4; i++) begin
            req_addr     = 18'(base + i);
            req_wdata    = {4'hB, 4'(k), 8'(base + i)};
            req_valid[k] = 1'b1;
            wait_ready(k);
            @(posedge clk);
            #1;
            acc[i] = cyc;
        end
        req_valid[k] = 1'b0;
        wait_ready(k);
        for (int i = 1; i < 4; i++) check("btb_period", acc[i] - acc[i-1], wc_of(k) + 3);
        for (int i = 0; i < 4; i++) run_read(k, 18'(base + i), 2'b11, {4'hB, 4'(k), 8'(base + i)});
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (3) @(negedge clk);
        check("rst_ce_n", 32'(ce_n[0]), 1);
        check("rst_oe_n", 32'(oe_n[0]), 1);
        check("rst_we_n", 32'(we_n[0]), 1);
        check("rst_be_n", 32'(be_n[0]), 32'h3);
        check("rst_dq_driven", 32'(g_dut[0].u_dut.u_dq_buf.i_drive_en), 0);
        check("rst_addr", 32'(sram_addr[0]), 0);
        check("rst_ready", 32'(req_ready[0]), 1);
        check("rst_rd_valid", 32'(rd_valid[0]), 0);
        check("rst_rd_data", 32'(rd_data[0]), 0);
        rst_n = 1'b1;

        // Write 0x0002 to addr 13 and check pin timing cycle by cycle.
        send(0, 1'b1, 18'd13, 16'h0002, 2'b11);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("wr_we_n", 32'(we_n[0]), (c <= 2) ? 0 : 1);
            check("wr_ce_n", 32'(ce_n[0]), (c <= 2) ? 0 : 1);
            check("wr_oe_n", 32'(oe_n[0]), 1);
            check("wr_dq", 32'(g_dut[0].dq), 32'h0002);
            check("wr_addr", 32'(sram_addr[0]), 13);
            check("wr_ready", 32'(req_ready[0]), 0);
        end
        @(negedge clk);
        check("wr_ready_c4", 32'(req_ready[0]), 1);
        check("wr_released", 32'(g_dut[0].u_dut.u_dq_buf.i_drive_en), 0);
        run_read(0, 18'd13, 2'b11, 16'h0002);

        // Byte lanes, including an all-disabled read.
        write_op(0, 18'd5, 16'hA5A5, 2'b11);
        write_op(0, 18'd5, 16'h3C3C, 2'b01);
        run_read(0, 18'd5, 2'b11, 16'hA53C);
        run_read(0, 18'd5, 2'b10, 16'hA500);
        run_read(0, 18'd5, 2'b01, 16'h003C);
        run_read(0, 18'd5, 2'b00, 16'h0000);

        back_to_back(0, 20);

        // Asynchronous reset during the first ACCESS cycle of a write.
        send(0, 1'b1, 18'd30, 16'h1111, 2'b11);
        #4;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ce_n", 32'(ce_n[0]), 1);
        check("mid_rst_we_n", 32'(we_n[0]), 1);
        check("mid_rst_oe_n", 32'(oe_n[0]), 1);
        check("mid_rst_be_n", 32'(be_n[0]), 32'h3);
        check("mid_rst_released", 32'(g_dut[0].u_dut.u_dq_buf.i_drive_en), 0);
        check("mid_rst_ready", 32'(req_ready[0]), 1);
        check("mid_rst_rd_valid", 32'(rd_valid[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        write_op(0, 18'd31, 16'h2222, 2'b11);
        run_read(0, 18'd31, 2'b11, 16'h2222);

        // WAIT_CYC = 0 and 3 instances.
        write_op(1, 18'd7, 16'h1234, 2'b11);
        run_read(1, 18'd7, 2'b11, 16'h1234);
        back_to_back(1, 40);
        write_op(2, 18'd9, 16'hBEEF, 2'b11);
        run_read(2, 18'd9, 2'b10, 16'hBE00);
        back_to_back(2, 48);

        check("oe_drive_conflict_0", g_dut[0].viol, 0);
        check("oe_drive_conflict_1", g_dut[1].viol, 0);
        check("oe_drive_conflict_2", g_dut[2].viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
